ram: RTL and testbench
======================

Name: ram

Overview:
- Single-port synchronous RAM, 256 words x 8 bits; one clock, one address bus shared by read and write.
- Drop-in block-RAM-style storage for the processor/UART datapath.
- Registered (clocked) read with write-first semantics.
- Synchronous output reset; memory contents are never cleared by reset.

Parameters:
- ADDR_W, 8, address width; depth = 2**ADDR_W words.
- DATA_W, 8, word width in bits.
- WRITE_MODE, 0, 0 = write-first (douta shows new data on write), 1 = read-first (douta shows old contents on write), 2 = no-change (douta holds its value on write).

Ports:
- clka  input  1  Clock; all activity on the rising edge.
- rsta  input  1  Synchronous, active-high reset of the output register only.
- wea  input  1 (declared [0:0])  Write enable.
- addra  input  ADDR_W  Word address for read and write.
- dina  input  DATA_W  Write data.
- douta  output  DATA_W  Registered read data.

Behaviour:
- Storage: array of 2**ADDR_W words of DATA_W bits. Every word is initialised to 0 at power-up/simulation start.
- Write: at a rising clka edge with wea=1, mem[addra] <= dina. Writes happen every edge while wea=1, including with an unchanged address.
- Read latency: 1 cycle. douta after edge N reflects addra sampled at edge N. There is no combinational path from addra or dina to douta.
- Output when wea=1, by WRITE_MODE:
  - 0: douta <= dina.
  - 1: douta <= old mem[addra].
  - 2: douta holds its previous value.
- Output when wea=0: douta <= mem[addra].
- Reset: at an edge with rsta=1, douta <= 0.
  - rsta has priority over the douta update.
  - A write with wea=1 during reset still updates memory.
  - Memory contents are untouched by reset.
- douta reset value: 0. Before the first clock edge douta is also 0.
- Address range: all 2**ADDR_W addresses are valid; no out-of-range case exists.
- Back-to-back access: a write at edge N followed by a read of the same address at edge N+1 returns the new data (no hazard).
- X on wea is treated as a no-write.

Optional Feature:
- Macro: RAM_OUTREG_EN.
- Defined: adds a second output pipeline register after the read register. Read latency becomes 2 cycles. rsta clears both registers to 0. Write-mode rules apply at the first stage.
- Undefined: single register, 1-cycle latency, as specified above.

Decomposition:
- Shared package ram_pkg holds:
  - default ADDR_W/DATA_W constants;
  - WRITE_MODE enum constants WR_FIRST=0, RD_FIRST=1, NO_CHANGE=2.
- Sub-module ram_array: pure storage with synchronous write and registered read, no reset.
- Top ram adds the write-mode muxing, the reset, and the optional output register around ram_array.

Test Plan:
- Power-up: no writes, addra=0x00, run 5 cycles -> douta=0x00 throughout.
- Write-first: wea=1, addra=0x00, dina=0x00, then addra=0x0F, dina=0xAA with wea=1 -> one edge later douta=0xAA; with wea=0 and addra=0x0F the next cycle -> douta=0xAA.
- Address change with wea held 1: after the above, addra=0x55 with dina=0xAA -> mem[0x55]=0xAA. Subsequent reads with wea=0: addr 0x55 -> 0xAA, addr 0x0F -> 0xAA, addr 0x00 -> 0x00, addr 0x10 -> 0x00.
- Read-first (WRITE_MODE=1): mem[0x20]=0x11, then write 0x22 to 0x20 -> douta=0x11 on that edge; a following read -> 0x22.
- Reset: douta=0xAA, assert rsta one cycle with wea=1, addra=0x30, dina=0x5C -> douta=0x00 that cycle; after deassert, reading 0x30 -> 0x5C and reading 0x0F -> 0xAA (contents preserved).
- RAM_OUTREG_EN defined: write 0x3C to 0x01, then read 0x01 -> douta=0x3C exactly 2 edges after the address is sampled; douta is still the old value 1 edge after.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants for the ram block: default geometry and the write-mode encoding.
package ram_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      WR_FIRST  = 2'd0,
      RD_FIRST  = 2'd1,
      NO_CHANGE = 2'd2
   } write_mode_e;

endpackage

// File: rtl/ram_array.sv
// Raw storage: synchronous write and a registered read of the pre-write contents, no reset.
module ram_array
   import ram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};
   logic [DATA_W-1:0] rd_q = '0;

   // An X on we fails the test and leaves the word untouched.
   always_ff @(posedge clk) begin
      if (we == 1'b1) begin
         mem[addr] <= din;
      end
      rd_q <= mem[addr];
   end

   assign rd_data = rd_q;

endmodule

// File: rtl/ram.sv
// Single-port synchronous RAM with selectable write mode and reset of the output only.
// Define RAM_OUTREG_EN to add a second output register (2-cycle read latency).
module ram
   import ram_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int WRITE_MODE = 0
) (
   input  logic              clka,
   input  logic              rsta,
   input  logic [0:0]        wea,
   input  logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] dina,
   output logic [DATA_W-1:0] douta
);

   logic [DATA_W-1:0] rd_data;
   logic              rst_q  = 1'b0;
   logic              wr_q   = 1'b0;
   logic [DATA_W-1:0] din_q  = '0;
   logic [DATA_W-1:0] held_q = '0;
   logic [DATA_W-1:0] stage1;

   ram_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk     (clka),
      .we      (wea[0]),
      .addr    (addra),
      .din     (dina),
      .rd_data (rd_data)
   );

   // The array always returns old contents; the control captured alongside it
   // decides what the first output stage shows for the same edge.
   always_ff @(posedge clka) begin
      rst_q  <= rsta;
      din_q  <= dina;
      held_q <= stage1;
      if (wea == 1'b1) begin
         wr_q <= 1'b1;
      end else begin
         wr_q <= 1'b0;
      end
   end

   always_comb begin
      stage1 = rd_data;
      if (rst_q) begin
         stage1 = '0;
      end else if (wr_q) begin
         if (WRITE_MODE == int'(WR_FIRST)) begin
            stage1 = din_q;
         end else if (WRITE_MODE == int'(NO_CHANGE)) begin
            stage1 = held_q;
         end else begin
            stage1 = rd_data;
         end
      end
   end

`ifdef RAM_OUTREG_EN
   logic [DATA_W-1:0] out_q = '0;

   always_ff @(posedge clka) begin
      if (rsta) begin
         out_q <= '0;
      end else begin
         out_q <= stage1;
      end
   end

   assign douta = out_q;
`else
   assign douta = stage1;
`endif

endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: three instances (write-first, read-first, no-change) share stimulus.
module tb_ram;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [0:0] we  = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] din  = 8'h00;
   logic [7:0] dout0, dout1, dout2;

   int errors = 0;
   int checks = 0;

   // Expected first-stage values from the previous step, used when the output register is present.
   logic [7:0] prev0 = 8'h00, prev1 = 8'h00, prev2 = 8'h00;

   always #5 clk = ~clk;

   ram #(.ADDR_W(8), .DATA_W(8), .WRITE_MODE(0)) dut0 (
      .clka(clk), .rsta(rst), .wea(we), .addra(addr), .dina(din), .douta(dout0));
   ram #(.ADDR_W(8), .DATA_W(8), .WRITE_MODE(1)) dut1 (
      .clka(clk), .rsta(rst), .wea(we), .addra(addr), .dina(din), .douta(dout1));
   ram #(.ADDR_W(8), .DATA_W(8), .WRITE_MODE(2)) dut2 (
      .clka(clk), .rsta(rst), .wea(we), .addra(addr), .dina(din), .douta(dout2));

   task automatic check3(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2);
      checks++;
      assert (dout0 === e0) else begin
         errors++;
         $error("FAIL %s wr_first observed=%h expected=%h", tag, dout0, e0);
      end
      checks++;
      assert (dout1 === e1) else begin
         errors++;
         $error("FAIL %s rd_first observed=%h expected=%h", tag, dout1, e1);
      end
      checks++;
      assert (dout2 === e2) else begin
         errors++;
         $error("FAIL %s no_change observed=%h expected=%h", tag, dout2, e2);
      end
   endtask

   // One clock: drive inputs, take the edge, check #1 later. e0..e2 are the
   // single-register expectations; with the extra register they appear one step later.
   task automatic step(input string tag, input logic r, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2);
      rst  = r;
      we   = w;
      addr = a;
      din  = d;
      @(posedge clk);
      #1;
`ifdef RAM_OUTREG_EN
      if (r) check3(tag, 8'h00, 8'h00, 8'h00);
      else   check3(tag, prev0, prev1, prev2);
`else
      check3(tag, e0, e1, e2);
`endif
      prev0 = e0;
      prev1 = e1;
      prev2 = e2;
   endtask

   initial begin
      #1;
      check3("pre_clock", 8'h00, 8'h00, 8'h00);

      for (int i = 0; i < 5; i++) begin
         step("power_up", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      end

      // Write path and write-mode behaviour
      step("wr_00",      1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      step("wr_0f",      1'b0, 1'b1, 8'h0F, 8'hAA, 8'hAA, 8'h00, 8'h00);
      step("rd_0f",      1'b0, 1'b0, 8'h0F, 8'h00, 8'hAA, 8'hAA, 8'hAA);
      step("wr_55",      1'b0, 1'b1, 8'h55, 8'hAA, 8'hAA, 8'h00, 8'hAA);
      step("rd_55",      1'b0, 1'b0, 8'h55, 8'h00, 8'hAA, 8'hAA, 8'hAA);
      step("rd_0f_b",    1'b0, 1'b0, 8'h0F, 8'h00, 8'hAA, 8'hAA, 8'hAA);
      step("rd_00",      1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      step("rd_10",      1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);

      // Old-versus-new data on consecutive writes to one address
      step("wr_20_11",   1'b0, 1'b1, 8'h20, 8'h11, 8'h11, 8'h00, 8'h00);
      step("wr_20_22",   1'b0, 1'b1, 8'h20, 8'h22, 8'h22, 8'h11, 8'h00);
      step("rd_20",      1'b0, 1'b0, 8'h20, 8'h00, 8'h22, 8'h22, 8'h22);

      // Reset clears the output but a concurrent write still lands
      step("rd_0f_pre",  1'b0, 1'b0, 8'h0F, 8'h00, 8'hAA, 8'hAA, 8'hAA);
      step("rst_wr_30",  1'b1, 1'b1, 8'h30, 8'h5C, 8'h00, 8'h00, 8'h00);
      step("rd_30",      1'b0, 1'b0, 8'h30, 8'h00, 8'h5C, 8'h5C, 8'h5C);
      step("rd_0f_post", 1'b0, 1'b0, 8'h0F, 8'h00, 8'hAA, 8'hAA, 8'hAA);

      // Overwrite while the output shows the old word
      step("wr_0f_77",   1'b0, 1'b1, 8'h0F, 8'h77, 8'h77, 8'hAA, 8'hAA);
      step("rd_0f_77",   1'b0, 1'b0, 8'h0F, 8'h00, 8'h77, 8'h77, 8'h77);

      // Write then read back-to-back at the top address and at 0x01
      step("wr_ff",      1'b0, 1'b1, 8'hFF, 8'h96, 8'h96, 8'h00, 8'h77);
      step("wr_01",      1'b0, 1'b1, 8'h01, 8'h3C, 8'h3C, 8'h00, 8'h77);
      step("rd_01",      1'b0, 1'b0, 8'h01, 8'h00, 8'h3C, 8'h3C, 8'h3C);
      step("rd_ff",      1'b0, 1'b0, 8'hFF, 8'h00, 8'h96, 8'h96, 8'h96);
      step("rd_00_b",    1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      step("idle",       1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
